adapter_ppfifo_mc_2_axi_stream: RTL and testbench
=================================================

# adapter_ppfifo_mc_2_axi_stream

Multi-channel successor to the single-port ping-pong-FIFO-to-AXI-Stream adapter. It round-robin arbitrates across CHANNELS ping-pong FIFO read ports and drains one whole block at a time into a single registered AXI4-Stream master. Each beat carries TDEST = source channel. TLAST is generated either from a per-channel frame length or at each block end. It sits between per-source video/data FIFOs and a shared AXI-Stream consumer such as a DMA write engine or overlay mixer.

## Interface
- DATA_WIDTH, 32, AXI data width
- STROBE_WIDTH, DATA_WIDTH/8, o_axi_keep width
- USER_WIDTH, 1, user bits carried above data in each FIFO word
- CHANNELS, 2, number of ping-pong FIFO ports (1..4)
- DEST_WIDTH, 2, TDEST width; CHANNELS <= 2**DEST_WIDTH
- LAST_MODE, 0, 0 = TLAST by per-channel frame count; 1 = TLAST on last word of every block
- i_axi_clk  in  1  clock for all logic
- rst  in  1  reset; synchronous, active-high, sampled on i_axi_clk
- i_ppfifo_rdy  in  CHANNELS  block ready, one bit per channel
- o_ppfifo_act  out  CHANNELS  block activate, one-hot or zero
- i_ppfifo_size  in  CHANNELS*24  block size in words, channel c at [24c+:24]
- i_ppfifo_data  in  CHANNELS*(DATA_WIDTH+USER_WIDTH)  FWFT word; user bits at the MSBs
- o_ppfifo_stb  out  CHANNELS  read strobe, one-hot or zero
- i_total_out_size  in  CHANNELS*24  frame length in words per channel (LAST_MODE=0)
- i_axi_ready  in  1  TREADY
- o_axi_valid  out  1  TVALID
- o_axi_data  out  DATA_WIDTH  TDATA
- o_axi_user  out  USER_WIDTH  TUSER
- o_axi_keep  out  STROBE_WIDTH  TKEEP, constant all ones
- o_axi_dest  out  DEST_WIDTH  TDEST = granted channel index
- o_axi_last  out  1  TLAST

## Operation
- States: IDLE, GRANT, READ, RELEASE.
- IDLE:
  - If any rdy bit is set, the round-robin arbiter selects the first set bit at or after rr_ptr (wrapping).
  - Register the selected index as r_ch and go to GRANT.
- GRANT: set o_ppfifo_act[r_ch]=1, r_count=0, go to READ.
- READ:
  - fetch = (r_count < size[r_ch]) && (!o_axi_valid || i_axi_ready).
  - o_ppfifo_stb[r_ch] = fetch, combinational.
  - On fetch, load the output register and increment r_count:
    - data = word[DATA_WIDTH-1:0]
    - user = word MSBs
    - dest = r_ch
    - last = computed last flag
  - When r_count == size[r_ch] with no fetch in that cycle: drop act, set rr_ptr = r_ch+1 (mod CHANNELS), go to RELEASE.
- RELEASE: one dead cycle, then IDLE.
- Output register:
  - A beat is consumed when valid && ready.
  - Valid is cleared on consume without fetch; it holds while !ready.
  - Data/user/dest/last stay stable while valid && !ready.
  - The last beat of a block may remain pending across the next block's GRANT.
- Last flag:
  - LAST_MODE=0: per-channel r_frame[c], 24 bits. last = (r_frame[c]+1 >= i_total_out_size[c]). On fetch, r_frame[c] becomes 0 if last, else increments. A frame spans blocks of the same channel. Other channels' blocks interleave without disturbing r_frame[c]. total_out_size 0 makes every beat last.
  - LAST_MODE=1: last = (r_count+1 == size[r_ch]).
- Zero-size block: act for exactly one READ cycle, no stb, then release.
- Arithmetic: all counters are 24-bit unsigned. Compares are done at 25 bits so the +1 never wraps.

## Timing
- Reset values:
  - All outputs 0, except o_axi_keep, which is all ones.
  - State IDLE, rr_ptr 0, r_count 0, all r_frame 0.
- Reset mid-block: act, stb and valid drop on the next edge. The partial beat is discarded.
- Latency:
  - rdy sampled high in IDLE at cycle 0.
  - act at cycle 2, with stb combinational in that cycle when the slot is free.
  - First o_axi_valid at cycle 3.
- Throughput: 1 beat/cycle inside a block while ready=1.
- Block-to-block overhead: 4 cycles (RELEASE, IDLE, GRANT, first fetch).
- No combinational path from i_axi_ready to any AXI output. i_axi_ready → o_ppfifo_stb is combinational.
- Simultaneous rdy on several channels: the grant goes to the first at or after rr_ptr; other channels wait for their turn.

## Structure
- Package adapter_ppfifo_pkg holds:
  - state enum {IDLE, GRANT, READ, RELEASE}
  - SIZE_WIDTH=24
  - function last_calc(count, size)
- Sub-module ppfifo_rr_arbiter #(CHANNELS): inputs req, ptr; outputs grant index and any. Purely combinational, 20-40 lines.

## Test plan
- CHANNELS=1, LAST_MODE=1, size 4, ready=1 → data D0..D3 valid on consecutive cycles 3..6, last on D3 only, dest 0; act drops after the 4th stb.
- CHANNELS=2, both rdy at once, sizes 3 and 2, rr_ptr 0 → ch0 beats (dest 0) then ch1 beats (dest 1). The next concurrent rdy grants ch0 first again, since rr_ptr has wrapped to 0.
- LAST_MODE=0, ch0 total_out_size 5, ch0 blocks of 3 interleaved with a ch1 block → last on the 5th ch0 beat (2nd block, index 1). Ch1 beats unaffected.
- Backpressure: ready toggles 1,0,0,1 during a size-8 block → no lost or duplicated words, outputs stable while !ready, stb only in cycles where the slot frees.
- Zero-size block on ch1 → act high for one cycle, no stb, no valid beat, next block proceeds.
- rst asserted for 1 cycle mid-block (after 2 of 6 beats) → all outputs reset the next cycle. The re-presented block is sent from word 0 with r_frame 0.

Source files
------------

// File: rtl/adapter_ppfifo_mc_2_axi_stream_pkg.sv
// adapter_ppfifo_pkg: shared FSM states, counter width and last-beat helper for the multi-channel ppfifo adapter
package adapter_ppfifo_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, READ, RELEASE} state_t;
  localparam int SIZE_WIDTH = 24;
  // Compared at SIZE_WIDTH+1 bits so count+1 never wraps.
  function automatic logic last_calc(input logic [SIZE_WIDTH-1:0] count, input logic [SIZE_WIDTH-1:0] size);
    return ({1'b0, count} + (SIZE_WIDTH+1)'(1)) == {1'b0, size};
  endfunction
endpackage

// File: rtl/adapter_ppfifo_mc_2_axi_stream_if.sv
// adapter_ppfifo_mc_2_axi_stream_if: AXI4-Stream bundle
//   valid/data/user/keep/dest/last driven by master, ready driven by slave
interface adapter_ppfifo_mc_2_axi_stream_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int DEST_WIDTH   = 2
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [USER_WIDTH-1:0]   user;
  logic [STROBE_WIDTH-1:0] keep;
  logic [DEST_WIDTH-1:0]   dest;
  logic                    last;
  modport master (output valid, data, user, keep, dest, last, input ready);
  modport slave (input valid, data, user, keep, dest, last, output ready);
endinterface

// File: rtl/adapter_ppfifo_mc_2_axi_stream_arbiter.sv
// ppfifo_rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req  : one request bit per channel
//   ptr  : channel index with highest priority
//   grant: selected channel index (valid when any)
//   any  : at least one request present
module ppfifo_rr_arbiter #(
  parameter int CHANNELS = 2,
  parameter int CW       = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       ptr,
  output logic [CW-1:0]       grant,
  output logic                any
);
  assign any = |req;
  // Walk from the farthest offset down so the nearest request at/after ptr wins.
  always_comb begin
    grant = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % CHANNELS]) grant = CW'((int'(ptr) + i) % CHANNELS);
  end
endmodule

// File: rtl/adapter_ppfifo_mc_2_axi_stream.sv
// adapter_ppfifo_mc_2_axi_stream: round-robin drain of CHANNELS ping-pong FIFO blocks into one registered AXI-Stream master
//   i_axi_clk, rst      : clock, synchronous active-high reset
//   i_ppfifo_rdy/size/data, o_ppfifo_act/stb : per-channel ping-pong FIFO read ports
//   i_total_out_size    : per-channel frame length in words (LAST_MODE=0)
//   axi                 : AXI-Stream master (TDEST = source channel)
module adapter_ppfifo_mc_2_axi_stream
  import adapter_ppfifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int CHANNELS     = 2,
  parameter int DEST_WIDTH   = 2,
  parameter int LAST_MODE    = 0
) (
  input  logic                                        i_axi_clk,
  input  logic                                        rst,
  input  logic [CHANNELS-1:0]                         i_ppfifo_rdy,
  output logic [CHANNELS-1:0]                         o_ppfifo_act,
  input  logic [CHANNELS*SIZE_WIDTH-1:0]              i_ppfifo_size,
  input  logic [CHANNELS*(DATA_WIDTH+USER_WIDTH)-1:0] i_ppfifo_data,
  output logic [CHANNELS-1:0]                         o_ppfifo_stb,
  input  logic [CHANNELS*SIZE_WIDTH-1:0]              i_total_out_size,
  adapter_ppfifo_mc_2_axi_stream_if.master            axi
);
  localparam int WW = DATA_WIDTH + USER_WIDTH;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  state_t state, state_n;
  logic [CW-1:0] ch, ptr, grant;
  logic any, fetch, done, act, valid, last, last_flag;
  logic [SIZE_WIDTH-1:0] count, size_c, total_c, frame_c;
  logic [SIZE_WIDTH-1:0] frame [CHANNELS];
  logic [WW-1:0] word;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;
  logic [DEST_WIDTH-1:0] dest;

  ppfifo_rr_arbiter #(.CHANNELS(CHANNELS), .CW(CW)) u_arb (
    .req  (i_ppfifo_rdy),
    .ptr  (ptr),
    .grant(grant),
    .any  (any)
  );

  assign size_c  = i_ppfifo_size[SIZE_WIDTH*ch +: SIZE_WIDTH];
  assign total_c = i_total_out_size[SIZE_WIDTH*ch +: SIZE_WIDTH];
  assign word    = i_ppfifo_data[WW*ch +: WW];
  assign frame_c = frame[ch];
  // A new word may be fetched only when the output slot is empty or drains this cycle.
  assign fetch = (state == READ) && (count < size_c) && (!valid || axi.ready);
  assign done  = (state == READ) && (count == size_c);
  // Frame mode compares at 25 bits: a total of 0 makes every beat last.
  assign last_flag = (LAST_MODE != 0) ? last_calc(count, size_c)
                   : (({1'b0, frame_c} + (SIZE_WIDTH+1)'(1)) >= {1'b0, total_c});

  assign o_ppfifo_act = act ? CHANNELS'(1) << ch : '0;
  assign o_ppfifo_stb = fetch ? CHANNELS'(1) << ch : '0;
  assign axi.valid = valid;
  assign axi.data  = data;
  assign axi.user  = user;
  assign axi.dest  = dest;
  assign axi.last  = last;
  assign axi.keep  = '1;

  always_ff @(posedge i_axi_clk) state <= rst ? IDLE : state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any ? GRANT : IDLE;
      GRANT:   state_n = READ;
      READ:    state_n = done ? RELEASE : READ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      ch    <= '0;
      ptr   <= '0;
      count <= '0;
      act   <= 1'b0;
      valid <= 1'b0;
      data  <= '0;
      user  <= '0;
      dest  <= '0;
      last  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) frame[i] <= '0;
    end else begin
      if (state == IDLE && any) ch <= grant;
      if (state == GRANT) begin
        act   <= 1'b1;
        count <= '0;
      end
      if (fetch) begin
        count <= count + SIZE_WIDTH'(1);
        valid <= 1'b1;
        data  <= word[DATA_WIDTH-1:0];
        user  <= word[WW-1:DATA_WIDTH];
        dest  <= DEST_WIDTH'(ch);
        last  <= last_flag;
        // Frame position is per channel so blocks of other channels can interleave.
        if (LAST_MODE == 0) frame[ch] <= last_flag ? '0 : frame_c + SIZE_WIDTH'(1);
      end else if (valid && axi.ready) valid <= 1'b0;
      if (done) begin
        act <= 1'b0;
        ptr <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_adapter_ppfifo_mc_2_axi_stream.sv
// tb_adapter_ppfifo_mc_2_axi_stream: self-checking bench for the multi-channel ppfifo to AXI-Stream adapter
module tb_adapter_ppfifo_mc_2_axi_stream;
  typedef struct {int ch; logic [32:0] w; logic last;} beat_t;
  typedef struct {bit rdy; bit rd; bit act; bit stb; bit vld; logic [31:0] d; bit last;} row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  rdy, act, stb;
  logic [47:0] size, total;
  logic [65:0] fdata;
  adapter_ppfifo_mc_2_axi_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(2)) ax ();
  adapter_ppfifo_mc_2_axi_stream #(.DATA_WIDTH(32), .USER_WIDTH(1), .CHANNELS(2), .DEST_WIDTH(2), .LAST_MODE(0)) u0 (
    .i_axi_clk(clk), .rst(rst), .i_ppfifo_rdy(rdy), .o_ppfifo_act(act), .i_ppfifo_size(size),
    .i_ppfifo_data(fdata), .o_ppfifo_stb(stb), .i_total_out_size(total), .axi(ax)
  );

  logic        rdy1, act1, stb1;
  logic [32:0] data1;
  adapter_ppfifo_mc_2_axi_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(2)) ax1 ();
  adapter_ppfifo_mc_2_axi_stream #(.DATA_WIDTH(32), .USER_WIDTH(1), .CHANNELS(1), .DEST_WIDTH(2), .LAST_MODE(1)) u1 (
    .i_axi_clk(clk), .rst(rst), .i_ppfifo_rdy(rdy1), .o_ppfifo_act(act1), .i_ppfifo_size(24'd4),
    .i_ppfifo_data(data1), .o_ppfifo_stb(stb1), .i_total_out_size(24'd0), .axi(ax1)
  );

  int checks = 0, errors = 0;
  logic [32:0] wq[2][$];
  int sq[2][$];
  int rd[2], act_cyc[2], stb_cnt[2], total_i[2];
  bit active[2];
  beat_t expq[$];
  bit hold_prev;
  logic [63:0] held;
  int rp = 100, cyc = 0, consumed = 0;
  bit pat = 0;
  bit bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < 2; c++) begin
      rdy[c] = sq[c].size() > 0 && !active[c];
      size[24*c +: 24] = sq[c].size() > 0 ? 24'(sq[c][0]) : 24'd0;
      fdata[33*c +: 33] = (sq[c].size() > 0 && rd[c] < sq[c][0]) ? wq[c][rd[c]] : 33'd0;
      total[24*c +: 24] = 24'(total_i[c]);
    end
  endtask

  task automatic next_ready();
    ax.ready = pat ? bp_pat[cyc % 4] : ($urandom_range(0, 99) < rp);
    cyc++;
  endtask

  task automatic add_blk(input int c, input int n);
    logic [32:0] w;
    sq[c].push_back(n);
    for (int i = 0; i < n; i++) begin
      w[31:0] = $urandom;
      w[32] = 1'($urandom_range(0, 1));
      wq[c].push_back(w);
    end
  endtask

  // Reference: strict round robin over channels with queued blocks, frame counters from 0.
  task automatic build_expected();
    int qs[2][$];
    int wi[2], fr[2];
    int p, c, n;
    beat_t b;
    expq.delete();
    p = 0;
    for (int k = 0; k < 2; k++) begin
      qs[k] = sq[k];
      wi[k] = 0;
      fr[k] = 0;
    end
    while (qs[0].size() + qs[1].size() > 0) begin
      c = qs[p].size() > 0 ? p : 1 - p;
      n = qs[c].pop_front();
      for (int i = 0; i < n; i++) begin
        b.ch = c;
        b.w = wq[c][wi[c] + i];
        b.last = (fr[c] + 1 >= total_i[c]);
        fr[c] = b.last ? 0 : fr[c] + 1;
        expq.push_back(b);
      end
      wi[c] += n;
      p = (c + 1) % 2;
    end
  endtask

  task automatic tick();
    beat_t e;
    logic [1:0] stb_s;
    logic [32:0] dummy;
    @(negedge clk);
    stb_s = stb;
    if (!rst) begin
      chk("act_onehot", 64'($countones(act) <= 1), 64'd1);
      chk("stb_in_act", 64'(stb & ~act), 64'd0);
      if (stb != 2'b00) chk("stb_slot_free", 64'(!ax.valid || ax.ready), 64'd1);
      if (hold_prev) chk("hold_stable", 64'({ax.valid, ax.user, ax.data, ax.dest, ax.last}), held);
      if (ax.valid && ax.ready) begin
        consumed++;
        chk("beat_expected", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("beat_dest", 64'(ax.dest), 64'(e.ch));
          chk("beat_word", 64'({ax.user, ax.data}), 64'(e.w));
          chk("beat_last", 64'(ax.last), 64'(e.last));
        end
      end
      hold_prev = ax.valid && !ax.ready;
      held = 64'({ax.valid, ax.user, ax.data, ax.dest, ax.last});
      for (int c = 0; c < 2; c++) begin
        act_cyc[c] += int'(act[c]);
        stb_cnt[c] += int'(stb[c]);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      hold_prev = 1'b0;
      for (int c = 0; c < 2; c++) begin
        active[c] = 1'b0;
        rd[c] = 0;
        act_cyc[c] = 0;
        stb_cnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        rd[c] += int'(stb_s[c]);
        if (active[c] && !act[c]) begin
          chk("blk_stb_count", 64'(stb_cnt[c]), 64'(sq[c][0]));
          if (sq[c][0] == 0) chk("zero_blk_act_cycles", 64'(act_cyc[c]), 64'd1);
          for (int i = 0; i < sq[c][0]; i++) dummy = wq[c].pop_front();
          void'(sq[c].pop_front());
          active[c] = 1'b0;
          rd[c] = 0;
          act_cyc[c] = 0;
          stb_cnt[c] = 0;
        end else if (act[c]) active[c] = 1'b1;
      end
    end
    next_ready();
    drive();
  endtask

  task automatic start_scn();
    rst = 1'b1;
    ax.ready = 1'b0;
    tick();
    rst = 1'b0;
    consumed = 0;
    build_expected();
    drive();
  endtask

  task automatic run(input int maxc);
    int n = 0;
    while (!(expq.size() == 0 && sq[0].size() == 0 && sq[1].size() == 0 && !ax.valid && act == 2'b00) && n < maxc) begin
      tick();
      n++;
    end
    chk("run_done", 64'(n < maxc), 64'd1);
    chk("beats_left", 64'(expq.size()), 64'd0);
  endtask

  row_t tbl[9];
  int idx1;
  bit s1;
  int nb;

  initial begin
    rst = 1'b1;
    rdy1 = 1'b0;
    data1 = '0;
    ax1.ready = 1'b0;
    ax.ready = 1'b0;
    total_i[0] = 0;
    total_i[1] = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    // Reset values of both instances.
    chk("rst_valid", 64'(ax.valid), 64'd0);
    chk("rst_data", 64'(ax.data), 64'd0);
    chk("rst_user", 64'(ax.user), 64'd0);
    chk("rst_dest", 64'(ax.dest), 64'd0);
    chk("rst_last", 64'(ax.last), 64'd0);
    chk("rst_keep", 64'(ax.keep), 64'hF);
    chk("rst_act", 64'(act), 64'd0);
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst1_valid", 64'(ax1.valid), 64'd0);
    rst = 1'b0;

    // Single channel, block-end TLAST, size 4, ready held high: cycle-accurate table.
    tbl[0] = '{1, 1, 0, 0, 0, 32'h0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 32'h0, 0};
    tbl[2] = '{0, 1, 1, 1, 0, 32'h0, 0};
    tbl[3] = '{0, 1, 1, 1, 1, 32'hD0, 0};
    tbl[4] = '{0, 1, 1, 1, 1, 32'hD1, 0};
    tbl[5] = '{0, 1, 1, 1, 1, 32'hD2, 0};
    tbl[6] = '{0, 1, 1, 0, 1, 32'hD3, 1};
    tbl[7] = '{0, 1, 0, 0, 0, 32'h0, 0};
    tbl[8] = '{0, 1, 0, 0, 0, 32'h0, 0};
    idx1 = 0;
    for (int i = 0; i < 9; i++) begin
      rdy1 = tbl[i].rdy;
      ax1.ready = tbl[i].rd;
      data1 = {1'b0, 32'hD0 + 32'(idx1)};
      @(negedge clk);
      chk($sformatf("t%0d_act", i), 64'(act1), 64'(tbl[i].act));
      chk($sformatf("t%0d_stb", i), 64'(stb1), 64'(tbl[i].stb));
      chk($sformatf("t%0d_valid", i), 64'(ax1.valid), 64'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("t%0d_data", i), 64'(ax1.data), 64'(tbl[i].d));
        chk($sformatf("t%0d_last", i), 64'(ax1.last), 64'(tbl[i].last));
        chk($sformatf("t%0d_dest", i), 64'(ax1.dest), 64'd0);
        chk($sformatf("t%0d_keep", i), 64'(ax1.keep), 64'hF);
      end
      s1 = stb1;
      @(posedge clk);
      #1;
      idx1 += int'(s1);
    end

    // Both channels ready together: ch0 then ch1, pointer wraps back to ch0.
    add_blk(0, 3); add_blk(0, 1); add_blk(1, 2); add_blk(1, 2);
    total_i[0] = 3; total_i[1] = 2; rp = 100; pat = 0;
    start_scn();
    run(300);

    // Frame spanning two ch0 blocks with a ch1 block between them.
    add_blk(0, 3); add_blk(0, 3); add_blk(1, 2);
    total_i[0] = 5; total_i[1] = 2;
    start_scn();
    run(300);

    // Backpressure 1,0,0,1 on a size-8 block.
    add_blk(0, 8);
    total_i[0] = 8; pat = 1;
    start_scn();
    run(400);
    pat = 0;

    // Zero-size block on ch1 between real blocks; ch1 frame length 0 makes every beat last.
    add_blk(0, 2); add_blk(1, 0); add_blk(1, 3);
    total_i[0] = 2; total_i[1] = 0;
    start_scn();
    run(300);

    // Reset after two of six beats: block restarts at word 0 with frame 0.
    add_blk(0, 6);
    total_i[0] = 4; rp = 100;
    start_scn();
    nb = 0;
    while (consumed < 2 && nb < 50) begin
      tick();
      nb++;
    end
    chk("pre_reset_beats", 64'(consumed), 64'd2);
    rst = 1'b1;
    rp = 0;
    ax.ready = 1'b0;
    tick();
    chk("midrst_valid", 64'(ax.valid), 64'd0);
    chk("midrst_act", 64'(act), 64'd0);
    chk("midrst_stb", 64'(stb), 64'd0);
    rst = 1'b0;
    rp = 100;
    ax.ready = 1'b1;
    build_expected();
    drive();
    run(300);

    // Randomized block mixes, frame lengths and ready density.
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 2; c++) begin
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) add_blk(c, $urandom_range(0, 7));
        total_i[c] = $urandom_range(0, 7);
      end
      rp = $urandom_range(30, 100);
      start_scn();
      run(3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
